// File: rtl/fmdll_lock_ctrl.sv
// Purpose : FMDLL lock acquisition - coarse Sel sweep, then MSB-first SAR search of the fine code.
// Latency : every trial is SETTLE_CYC+1 cycles; lock is reached (coarse trials + DLY_W)*(SETTLE_CYC+1) cycles after start.
// Backpres: none. start is ignored while busy; pd_up is sampled only at the end of a settle count.
// Option  : define FMDLL_LOCK_TRACK_EN to keep following pd_up in LOCKED with a 2-sample direction filter.
module fmdll_lock_ctrl #(
    parameter int DLY_W      = 4,
    parameter int SETTLE_CYC = 4,
    parameter int SEL_MAX    = 3
) (
    input  logic             i_clk_ext,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic             i_pd_up,
    output logic [1:0]       o_sel,
    output logic [DLY_W-1:0] o_dly_code,
    output logic             o_busy,
    output logic             o_locked,
    output logic             o_fail
);

    localparam int CNT_W = $clog2(SETTLE_CYC + 1);
    localparam int BIT_W = (DLY_W > 1) ? $clog2(DLY_W) : 1;

    localparam logic [DLY_W-1:0] CODE_ONE = DLY_W'(1);
    localparam logic [DLY_W-1:0] CODE_MID = CODE_ONE << (DLY_W - 1);
    localparam logic [DLY_W-1:0] CODE_MAX = '1;
    localparam logic [1:0]       SEL_TOP  = 2'(SEL_MAX);
    localparam logic [CNT_W-1:0] CNT_END  = CNT_W'(SETTLE_CYC);
    localparam logic [BIT_W-1:0] BIT_MSB  = BIT_W'(DLY_W - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_COARSE,
        ST_FINE,
        ST_LOCKED,
        ST_FAIL
    } state_t;

    state_t           r_state;
    logic [1:0]       r_sel;
    logic [DLY_W-1:0] r_code;
    logic [CNT_W-1:0] r_cnt;
    logic [BIT_W-1:0] r_bit;

    state_t           w_state_nxt;
    logic [1:0]       w_sel_nxt;
    logic [DLY_W-1:0] w_code_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [BIT_W-1:0] w_bit_nxt;
    logic [DLY_W-1:0] w_code_kept;
    logic             w_settled;

`ifdef FMDLL_LOCK_TRACK_EN
    logic r_flt_vld;
    logic r_flt_dir;
    logic w_flt_vld_nxt;
    logic w_flt_dir_nxt;
`endif

    assign w_settled = (r_cnt == CNT_END);

    // State and datapath registers; reset drops straight back to IDLE, abandoning any trial in flight.
    always_ff @(posedge i_clk_ext) begin
        if (i_rst) begin
            r_state   <= ST_IDLE;
            r_sel     <= '0;
            r_code    <= '0;
            r_cnt     <= '0;
            r_bit     <= '0;
`ifdef FMDLL_LOCK_TRACK_EN
            r_flt_vld <= 1'b0;
            r_flt_dir <= 1'b0;
`endif
        end else begin
            r_state   <= w_state_nxt;
            r_sel     <= w_sel_nxt;
            r_code    <= w_code_nxt;
            r_cnt     <= w_cnt_nxt;
            r_bit     <= w_bit_nxt;
`ifdef FMDLL_LOCK_TRACK_EN
            r_flt_vld <= w_flt_vld_nxt;
            r_flt_dir <= w_flt_dir_nxt;
`endif
        end
    end

    // Next-state logic: settle count, coarse sweep decisions, SAR bit decisions and (optionally) lock tracking.
    always_comb begin
        w_state_nxt   = r_state;
        w_sel_nxt     = r_sel;
        w_code_nxt    = r_code;
        w_cnt_nxt     = r_cnt;
        w_bit_nxt     = r_bit;
        w_code_kept   = r_code;
`ifdef FMDLL_LOCK_TRACK_EN
        w_flt_vld_nxt = r_flt_vld;
        w_flt_dir_nxt = r_flt_dir;
`endif

        case (r_state)
            ST_COARSE: begin
                if (!w_settled) begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end else begin
                    w_cnt_nxt = '0;
                    if (i_pd_up) begin
                        if (r_sel < SEL_TOP) begin
                            w_sel_nxt = r_sel + 2'd1;
                        end else begin
                            // Even the longest tap is still too short: give up, hold outputs.
                            w_state_nxt = ST_FAIL;
                        end
                    end else begin
                        // Overshot: drop back one tap and start the SAR with the MSB already set
                        // so the first fine trial begins on this very cycle.
                        w_sel_nxt   = (r_sel == 2'd0) ? 2'd0 : (r_sel - 2'd1);
                        w_code_nxt  = CODE_MID;
                        w_bit_nxt   = BIT_MSB;
                        w_state_nxt = ST_FINE;
                    end
                end
            end

            ST_FINE: begin
                if (!w_settled) begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end else begin
                    w_cnt_nxt = '0;
                    if (!i_pd_up) begin
                        w_code_kept = r_code & ~(CODE_ONE << r_bit);
                    end
                    if (r_bit == '0) begin
                        w_code_nxt  = w_code_kept;
                        w_state_nxt = ST_LOCKED;
`ifdef FMDLL_LOCK_TRACK_EN
                        w_flt_vld_nxt = 1'b0;
`endif
                    end else begin
                        w_code_nxt = w_code_kept | (CODE_ONE << (r_bit - BIT_W'(1)));
                        w_bit_nxt  = r_bit - BIT_W'(1);
                    end
                end
            end

            ST_LOCKED: begin
`ifdef FMDLL_LOCK_TRACK_EN
                if (!w_settled) begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end else begin
                    w_cnt_nxt = '0;
                    if (r_flt_vld && (r_flt_dir == i_pd_up)) begin
                        // Two agreeing samples: step one code; stepping off either end means
                        // the coarse tap is wrong, so reacquire from scratch.
                        w_flt_vld_nxt = 1'b0;
                        if (i_pd_up) begin
                            if (r_code == CODE_MAX) begin
                                w_state_nxt = ST_COARSE;
                                w_sel_nxt   = 2'd0;
                                w_code_nxt  = CODE_MID;
                            end else begin
                                w_code_nxt = r_code + CODE_ONE;
                            end
                        end else begin
                            if (r_code == '0) begin
                                w_state_nxt = ST_COARSE;
                                w_sel_nxt   = 2'd0;
                                w_code_nxt  = CODE_MID;
                            end else begin
                                w_code_nxt = r_code - CODE_ONE;
                            end
                        end
                    end else begin
                        w_flt_vld_nxt = 1'b1;
                        w_flt_dir_nxt = i_pd_up;
                    end
                end
`endif
            end

            default: begin
            end
        endcase

        // A new acquisition may only be launched from a resting state.
        if (i_start && ((r_state == ST_IDLE) || (r_state == ST_LOCKED) || (r_state == ST_FAIL))) begin
            w_state_nxt = ST_COARSE;
            w_sel_nxt   = 2'd0;
            w_code_nxt  = CODE_MID;
            w_cnt_nxt   = '0;
            w_bit_nxt   = '0;
`ifdef FMDLL_LOCK_TRACK_EN
            w_flt_vld_nxt = 1'b0;
`endif
        end
    end

    assign o_sel      = r_sel;
    assign o_dly_code = r_code;
    assign o_busy     = (r_state == ST_COARSE) || (r_state == ST_FINE);
    assign o_locked   = (r_state == ST_LOCKED);
    assign o_fail     = (r_state == ST_FAIL);

endmodule

// File: tb/tb_fmdll_lock_ctrl.sv
// Bench for fmdll_lock_ctrl: table of acquisition targets with a result scoreboard,
// plus hand-written sequences for reset, start/rst during FINE and the LOCKED behaviour.
// Plant model: pd_up asks for more delay while {Sel,dly_code} has not passed the target.
module tb_fmdll_lock_ctrl;

    logic       clk;
    logic       rst;
    logic       start;
    logic       pd_up;
    logic [1:0] sel;
    logic [3:0] code;
    logic       busy;
    logic       locked;
    logic       fail;

    logic [1:0] tsel;
    logic [3:0] tcode;
    logic       pd_mode;
    logic       pd_man;

    int n_vec;
    int n_err;

    typedef struct {
        logic [1:0] tsel;
        logic [3:0] tcode;
        logic       exp_lock;
        logic       exp_fail;
        logic [1:0] exp_sel;
        logic [3:0] exp_code;
        int         exp_cyc;
        int         glitch;
    } vec_t;

    vec_t tbl[6];
    vec_t exp_q[$];

    fmdll_lock_ctrl #(
        .DLY_W      (4),
        .SETTLE_CYC (4),
        .SEL_MAX    (3)
    ) dut (
        .i_clk_ext  (clk),
        .i_rst      (rst),
        .i_start    (start),
        .i_pd_up    (pd_up),
        .o_sel      (sel),
        .o_dly_code (code),
        .o_busy     (busy),
        .o_locked   (locked),
        .o_fail     (fail)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Phase-detector plant: "more delay" up to and including the target tap, or a manual override.
    assign pd_up = pd_mode ? pd_man : ({sel, code} <= {tsel, tcode});

    function automatic int outs();
        return int'({busy, locked, fail, sel, code});
    endfunction

    function automatic int pack(input logic b, input logic l, input logic f,
                                input logic [1:0] s, input logic [3:0] c);
        return int'({b, l, f, s, c});
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Launch one acquisition, log the expected result, then compare it when busy drops.
    task automatic run_vec(input vec_t v);
        vec_t e;
        int   k;
        tsel    = v.tsel;
        tcode   = v.tcode;
        pd_mode = 1'b0;
        start   = 1'b1;
        exp_q.push_back(v);
        @(negedge clk);
        start = 1'b0;
        chk("start_state", outs(), pack(1'b1, 1'b0, 1'b0, 2'd0, 4'd8));
        k = 0;
        while (busy && (k < 200)) begin
            @(negedge clk);
            k++;
            start = (v.glitch != 0) && (k == v.glitch);
        end
        start = 1'b0;
        e = exp_q.pop_front();
        chk("cycles", k, e.exp_cyc);
        chk("locked", int'(locked), int'(e.exp_lock));
        chk("fail", int'(fail), int'(e.exp_fail));
        chk("sel", int'(sel), int'(e.exp_sel));
        chk("code", int'(code), int'(e.exp_code));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_vec   = 0;
        n_err   = 0;
        rst     = 1'b1;
        start   = 1'b1;
        pd_mode = 1'b1;
        pd_man  = 1'b1;
        tsel    = 2'd0;
        tcode   = 4'd0;

        //                tsel tcode lock fail sel code cyc glitch
        tbl[0] = '{2'd2, 4'd9,  1'b1, 1'b0, 2'd2, 4'd9,  40, 0};
        tbl[1] = '{2'd3, 4'd15, 1'b0, 1'b1, 2'd3, 4'd8,  20, 0};
        tbl[2] = '{2'd0, 4'd3,  1'b1, 1'b0, 2'd0, 4'd3,  25, 0};
        tbl[3] = '{2'd1, 4'd15, 1'b1, 1'b0, 2'd1, 4'd15, 35, 0};
        tbl[4] = '{2'd3, 4'd0,  1'b1, 1'b0, 2'd2, 4'd15, 40, 25};
        tbl[5] = '{2'd0, 4'd0,  1'b1, 1'b0, 2'd0, 4'd0,  25, 12};

        // Reset held two cycles with start asserted.
        @(negedge clk);
        tick(1);
        chk("reset_outs", outs(), pack(1'b0, 1'b0, 1'b0, 2'd0, 4'd0));
        start = 1'b0;
        rst   = 1'b0;
        tick(3);
        chk("idle_after_reset", outs(), pack(1'b0, 1'b0, 1'b0, 2'd0, 4'd0));

        // Table-driven acquisitions (fail case followed by a start that must clear fail).
        for (int i = 0; i < 6; i++) begin
            run_vec(tbl[i]);
        end

        // Reset in the middle of FINE aborts at once and stays idle.
        tsel    = 2'd2;
        tcode   = 4'd9;
        pd_mode = 1'b0;
        start   = 1'b1;
        tick(1);
        start = 1'b0;
        tick(26);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        chk("rst_mid_fine", outs(), pack(1'b0, 1'b0, 1'b0, 2'd0, 4'd0));
        tick(10);
        chk("idle_after_abort", outs(), pack(1'b0, 1'b0, 1'b0, 2'd0, 4'd0));

`ifdef FMDLL_LOCK_TRACK_EN
        // Two agreeing "up" samples step the code from 9 to 10.
        run_vec(tbl[0]);
        pd_mode = 1'b1;
        pd_man  = 1'b1;
        tick(11);
        chk("track_step_up", outs(), pack(1'b0, 1'b1, 1'b0, 2'd2, 4'd10));
        // Alternating samples never step.
        for (int j = 0; j < 4; j++) begin
            pd_man = (j % 2 == 1);
            tick(5);
        end
        chk("track_alternate", outs(), pack(1'b0, 1'b1, 1'b0, 2'd2, 4'd10));
        // Stepping past code 15 drops lock and restarts the coarse sweep.
        run_vec(tbl[3]);
        pd_mode = 1'b1;
        pd_man  = 1'b1;
        tick(11);
        chk("track_overflow", outs(), pack(1'b1, 1'b0, 1'b0, 2'd0, 4'd8));
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
`else
        // Without tracking, LOCKED ignores pd_up entirely.
        run_vec(tbl[0]);
        pd_mode = 1'b1;
        for (int j = 0; j < 100; j++) begin
            pd_man = j[0];
            tick(1);
        end
        chk("locked_frozen", outs(), pack(1'b0, 1'b1, 1'b0, 2'd2, 4'd9));
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
